// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite types for the master and slave register-bank blocks.
package axilite_pkg;

  localparam int unsigned AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRsp,
    StDrain
  } master_state_t;

endpackage

// File: rtl/axilite_watchdog.sv
// Saturating response watchdog: hit fires in the cycle the count steps onto RESP_TIMEOUT-1.
module axilite_watchdog #(
  parameter int unsigned RESP_TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CW = $clog2(RESP_TIMEOUT) + 1;
  localparam logic [CW-1:0] Limit = CW'(RESP_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Limit)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Stays asserted once saturated so a held enable keeps reporting the timeout.
  assign hit = enable && !clear && (count_d == Limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axilite_master.sv
// AXI4-Lite initiator: one outstanding single-beat read or write, with watchdog DECERR
// and a drain phase that absorbs the late bus response after a timeout.
module axilite_master
  import axilite_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = 16,
  parameter int unsigned RESP_TIMEOUT      = 32
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          AXI_AWVALID,
  output logic [AXI_ADDRESS_WIDTH-1:0]  AXI_AWADDR,
  input  logic                          AXI_AWREADY,
  output logic                          AXI_WVALID,
  output logic [AXI_DATA_WIDTH-1:0]     AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                          AXI_WREADY,
  input  logic                          AXI_BVALID,
  input  logic [1:0]                    AXI_BRESP,
  output logic                          AXI_BREADY,
  output logic                          AXI_ARVALID,
  output logic [AXI_ADDRESS_WIDTH-1:0]  AXI_ARADDR,
  input  logic                          AXI_ARREADY,
  input  logic                          AXI_RVALID,
  input  logic [1:0]                    AXI_RRESP,
  input  logic [AXI_DATA_WIDTH-1:0]     AXI_RDATA,
  output logic                          AXI_RREADY
);

  localparam logic [AXI_ADDRESS_WIDTH-1:0] AddrLsbMask = AXI_ADDRESS_WIDTH'(3);

  master_state_t                   state_q, state_d;
  logic [AXI_ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH/8-1:0]     wstrb_q, wstrb_d;
  logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
  logic b_pend_q, b_pend_d, r_pend_q, r_pend_d, drain_pend_q, drain_pend_d;
  logic [AXI_DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  axi_resp_t                       rsp_resp_q, rsp_resp_d;
  logic                            rsp_timeout_q, rsp_timeout_d;

  logic accept, b_hs, r_hs, wd_en, wd_hit, any_pend;

  assign cmd_ready = (state_q == StIdle) && !AXI_RESET;
  assign accept    = cmd_valid && cmd_ready;
  assign b_hs      = b_pend_q && AXI_BVALID;
  assign r_hs      = r_pend_q && AXI_RVALID;
  assign wd_en     = (state_q == StWr) || (state_q == StRd);
  assign any_pend  = aw_pend_q || w_pend_q || ar_pend_q || b_pend_q || r_pend_q;

  axilite_watchdog #(
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) u_watchdog (
    .clk    (AXI_ACLK),
    .rst    (AXI_RESET),
    .clear  (accept),
    .enable (wd_en),
    .hit    (wd_hit)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    // Each flag retires on its own handshake regardless of FSM state.
    aw_pend_d     = aw_pend_q && !AXI_AWREADY;
    w_pend_d      = w_pend_q && !AXI_WREADY;
    ar_pend_d     = ar_pend_q && !AXI_ARREADY;
    b_pend_d      = b_pend_q && !AXI_BVALID;
    r_pend_d      = r_pend_q && !AXI_RVALID;
    drain_pend_d  = drain_pend_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = cmd_addr & ~AddrLsbMask;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            b_pend_d  = 1'b1;
            state_d   = StWr;
          end else begin
            ar_pend_d = 1'b1;
            r_pend_d  = 1'b1;
            state_d   = StRd;
          end
        end
      end
      StWr: begin
        if (b_hs) begin
          rsp_resp_d    = axi_resp_t'(AXI_BRESP);
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end else if (wd_hit) begin
          rsp_resp_d    = RespDecErr;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          drain_pend_d  = 1'b1;
          state_d       = StRsp;
        end
      end
      StRd: begin
        if (r_hs) begin
          rsp_resp_d    = axi_resp_t'(AXI_RRESP);
          rsp_rdata_d   = AXI_RDATA;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end else if (wd_hit) begin
          rsp_resp_d    = RespDecErr;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          drain_pend_d  = 1'b1;
          state_d       = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d = drain_pend_q ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (!any_pend) begin
          drain_pend_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      ar_pend_q     <= 1'b0;
      b_pend_q      <= 1'b0;
      r_pend_q      <= 1'b0;
      drain_pend_q  <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RespOkay;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      ar_pend_q     <= ar_pend_d;
      b_pend_q      <= b_pend_d;
      r_pend_q      <= r_pend_d;
      drain_pend_q  <= drain_pend_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_valid   = (state_q == StRsp);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign AXI_AWVALID = aw_pend_q;
  assign AXI_AWADDR  = addr_q;
  assign AXI_WVALID  = w_pend_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign AXI_BREADY  = b_pend_q;
  assign AXI_ARVALID = ar_pend_q;
  assign AXI_ARADDR  = addr_q;
  assign AXI_RREADY  = r_pend_q;

endmodule
